qft_phase_sequencer: RTL and testbench
======================================

Name: qft_phase_sequencer

Overview:
- Upstream feeder for the pipelined piecewise-linear cosine stage in the QFT datapath.
- On a start pulse, generates a burst of COUNT fixed-point angles: phase0, phase0+step, phase0+2·step, …
- Wraps every angle into the cosine stage's domain [-PI_FX, PI_FX-1] and drives one angle per cycle, with no backpressure.
- Carries valid and last through a shift register matched to the cosine latency, so downstream logic sees flags aligned with y.

Parameters:
- ANGLE_W, `TOTAL_WIDTH: angle/step width, signed, same Q-format as the cosine stage.
- CNT_W, 8: burst-length counter width.
- PI_FX, 101: round(pi·2^FRAC_WIDTH).
- TWO_PI_FX, 201: wrap modulus.
- HALF_PI_FX, 50: quadrature offset, used only with the optional feature.
- COS_LATENCY, 3: register stages from cosine input x to output y.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- phase0  in  ANGLE_W  signed start angle; any value with |phase0| < 2·PI_FX.
- step  in  ANGLE_W  signed increment; |step| <= PI_FX.
- count  in  CNT_W  number of angles to emit; 0 is legal.
- x  out  ANGLE_W  registered wrapped angle to the cosine stage.
- x_valid  out  1  x holds a burst sample.
- x_last  out  1  final sample of the burst, qualified by x_valid.
- y_valid  out  1  x_valid delayed COS_LATENCY cycles; aligned with the cosine y.
- y_last  out  1  x_last delayed COS_LATENCY cycles.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, accumulator 0, delay line cleared, state IDLE. Reset asserted mid-burst aborts the burst immediately; no done is issued.
- wrap(v) is computed at ANGLE_W+2 bits:
  - v >= PI_FX → v-TWO_PI_FX
  - v < -PI_FX → v+TWO_PI_FX
  - otherwise v unchanged.
  - A single correction is sufficient under the input limits; inputs outside the limits give undefined values but the FSM still behaves correctly.
- IDLE:
  - start=1, count>0: acc<=wrap(phase0), rem<=count, go RUN.
  - start=1, count=0: go DRAIN with the delay line empty; done pulses one cycle after start is sampled.
  - start=0: stay in IDLE.
- RUN, every cycle:
  - x<=acc, x_valid<=1, x_last<=(rem==1).
  - acc<=wrap(acc+step), rem<=rem-1.
  - When rem==1, go DRAIN.
  - The first x_valid appears in the cycle after start is sampled; samples are contiguous.
- DRAIN:
  - x_valid<=0, x_last<=0, x holds its last value.
  - Stay until the delay line is empty, i.e. the cycle in which y_last is high.
  - Next cycle: done=1 for one cycle, busy=0, go IDLE.
  - For count=N>0, done follows start by N+COS_LATENCY+1 cycles.
- start while busy: ignored and not queued. start in the same cycle done is high: also ignored.
- Delay line: COS_LATENCY-deep shift of {x_valid, x_last}, cleared by reset.

Optional Feature:
- Macro: QFT_PHASE_QUAD_EN.
- When defined:
  - Adds output x_q (ANGLE_W), registered with x, equal to wrap(acc-HALF_PI_FX).
  - A second cosine instance fed by x_q produces sin; both share y_valid/y_last.
- When undefined: x_q port and its logic are absent.

Decomposition:
- Shared package/header qft_phase_pkg:
  - PI_FX, TWO_PI_FX, HALF_PI_FX, COS_LATENCY.
  - State encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- Sub-module phase_wrap: combinational wrap() with parameter ANGLE_W.
  - One instance for the accumulator path, one for the initial load, one for x_q when enabled.

Test Plan:
- Basic burst: phase0=0, step=13, count=4 → x=0,13,26,39 on 4 consecutive cycles starting one cycle after start. x_last on 39. y_valid is the same pattern 3 cycles later. done 8 cycles after start.
- Positive wrap: phase0=90, step=20, count=3 → x=90, -91, -71.
- Negative wrap: phase0=-95, step=-10, count=3 → x=-95, 96, 86.
- Zero count: count=0 → x_valid never asserts; done=1 exactly one cycle after start; busy high for that one cycle only.
- Busy and reset: start pulsed again mid-burst → ignored, output sequence unchanged. Then rst_n low for 1 cycle mid-burst → all outputs 0 and state IDLE; a new start works normally.
- QUAD (macro defined): phase0=0, step=0, count=2 → x=0,0 and x_q=-50,-50. Then phase0=-80, count=1 → x_q=71.

Source files
------------

// File: rtl/qft_phase_sequencer_pkg.sv
// Shared constants, state encoding and flag payload for the QFT phase sequencer.
// ANGLE_W follows `TOTAL_WIDTH when the datapath defines it, else 16 bits.
// Optional feature macro used by the sequencer: QFT_PHASE_QUAD_EN.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

package qft_phase_pkg;

  localparam int unsigned ANGLE_W     = `TOTAL_WIDTH;
  localparam int unsigned ANGLE_EXT_W = ANGLE_W + 2;
  localparam int unsigned CNT_W       = 8;

  localparam int PI_FX      = 101;
  localparam int TWO_PI_FX  = 201;
  localparam int HALF_PI_FX = 50;

  localparam int unsigned COS_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Sideband flags travelling alongside the cosine pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } flag_t;

endpackage

// File: rtl/qft_phase_sequencer_if.sv
// Burst request / angle stream bundle between the sequencer and its neighbours.
// Request: start, phase0, step, count. Stream: x, x_valid, x_last, y_valid,
// y_last, busy, done, plus x_q when QFT_PHASE_QUAD_EN is defined.
interface qft_phase_sequencer_if;
  import qft_phase_pkg::*;

  logic                      start;
  logic signed [ANGLE_W-1:0] phase0;
  logic signed [ANGLE_W-1:0] step;
  logic [CNT_W-1:0]          count;
  logic signed [ANGLE_W-1:0] x;
`ifdef QFT_PHASE_QUAD_EN
  logic signed [ANGLE_W-1:0] x_q;
`endif
  logic                      x_valid;
  logic                      x_last;
  logic                      y_valid;
  logic                      y_last;
  logic                      busy;
  logic                      done;

  modport master (
    output start, phase0, step, count,
`ifdef QFT_PHASE_QUAD_EN
    input  x_q,
`endif
    input  x, x_valid, x_last, y_valid, y_last, busy, done
  );

  modport slave (
    input  start, phase0, step, count,
`ifdef QFT_PHASE_QUAD_EN
    output x_q,
`endif
    output x, x_valid, x_last, y_valid, y_last, busy, done
  );

endinterface

// File: rtl/qft_phase_sequencer_wrap.sv
// Combinational wrap of an extended-width angle into [-PI_FX, PI_FX-1].
// Ports: v (ANGLE_W+2 signed, unwrapped), w_c (ANGLE_W signed, wrapped).
// One correction suffices because callers keep |v| below 3*PI_FX.
module phase_wrap #(
  parameter int unsigned ANGLE_W = 16
) (
  input  logic signed [ANGLE_W+1:0] v,
  output logic signed [ANGLE_W-1:0] w_c
);
  import qft_phase_pkg::PI_FX;
  import qft_phase_pkg::TWO_PI_FX;

  localparam int unsigned EXT_W = ANGLE_W + 2;
  localparam logic signed [EXT_W-1:0] PI_V     = EXT_W'(PI_FX);
  localparam logic signed [EXT_W-1:0] NEG_PI_V = EXT_W'(-PI_FX);
  localparam logic signed [EXT_W-1:0] TWO_PI_V = EXT_W'(TWO_PI_FX);

  logic signed [EXT_W-1:0] r_c;

  always_comb begin
    r_c = v;
    if (v >= PI_V) begin
      r_c = v - TWO_PI_V;
    end else if (v < NEG_PI_V) begin
      r_c = v + TWO_PI_V;
    end
    w_c = ANGLE_W'(r_c);
  end

endmodule

// File: rtl/qft_phase_sequencer.sv
// Angle burst generator feeding the pipelined cosine stage.
// Ports: clk, rst_n (async, active-low), bus (slave side of
// qft_phase_sequencer_if). With QFT_PHASE_QUAD_EN defined, also drives x_q,
// the quadrature angle wrap(acc - HALF_PI_FX) registered alongside x.
module qft_phase_sequencer
  import qft_phase_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  qft_phase_sequencer_if.slave   bus
);

  state_t                        state_q, state_d;
  logic signed [ANGLE_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]              rem_q, rem_d;
  logic signed [ANGLE_W-1:0]     x_r, x_d;
  logic                          xv_r, xv_d;
  logic                          xl_r, xl_d;
  logic                          busy_r, busy_d;
  logic                          done_r, done_d;
  flag_t                         dl_q [COS_LATENCY];
  logic                          pending_c;

  logic signed [ANGLE_EXT_W-1:0] load_v_c, next_v_c;
  logic signed [ANGLE_W-1:0]     load_w_c, next_w_c;

  assign load_v_c = ANGLE_EXT_W'(bus.phase0);
  assign next_v_c = ANGLE_EXT_W'(acc_q) + ANGLE_EXT_W'(bus.step);

  phase_wrap #(.ANGLE_W(ANGLE_W)) u_wrap_load (.v(load_v_c), .w_c(load_w_c));
  phase_wrap #(.ANGLE_W(ANGLE_W)) u_wrap_acc  (.v(next_v_c), .w_c(next_w_c));

`ifdef QFT_PHASE_QUAD_EN
  logic signed [ANGLE_EXT_W-1:0] quad_v_c;
  logic signed [ANGLE_W-1:0]     quad_w_c;
  logic signed [ANGLE_W-1:0]     xq_r, xq_d;

  assign quad_v_c = ANGLE_EXT_W'(acc_q) - ANGLE_EXT_W'(HALF_PI_FX);

  phase_wrap #(.ANGLE_W(ANGLE_W)) u_wrap_quad (.v(quad_v_c), .w_c(quad_w_c));
`endif

  // A sample is still in flight unless only the final delay stage may hold it.
  always_comb begin
    pending_c = xv_r;
    for (int unsigned i = 0; i + 1 < COS_LATENCY; i++) begin
      pending_c = pending_c | dl_q[i].valid;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    x_d     = x_r;
    xv_d    = 1'b0;
    xl_d    = 1'b0;
    done_d  = 1'b0;
`ifdef QFT_PHASE_QUAD_EN
    xq_d    = xq_r;
`endif
    case (state_q)
      ST_IDLE: begin
        // start coinciding with the done pulse is dropped.
        if (bus.start && !done_r) begin
          if (bus.count != '0) begin
            acc_d   = load_w_c;
            rem_d   = bus.count;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_RUN: begin
        x_d   = acc_q;
        xv_d  = 1'b1;
        xl_d  = (rem_q == CNT_W'(1));
        acc_d = next_w_c;
        rem_d = rem_q - CNT_W'(1);
`ifdef QFT_PHASE_QUAD_EN
        xq_d  = quad_w_c;
`endif
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pending_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      x_r     <= '0;
      xv_r    <= 1'b0;
      xl_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      x_r     <= x_d;
      xv_r    <= xv_d;
      xl_r    <= xl_d;
      busy_r  <= busy_d;
      done_r  <= done_d;
    end
  end

`ifdef QFT_PHASE_QUAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xq_r <= '0;
    end else begin
      xq_r <= xq_d;
    end
  end

  assign bus.x_q = xq_r;
`endif

  // Flag delay line matched to the cosine latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < COS_LATENCY; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      dl_q[0] <= '{valid: xv_r, last: xl_r};
      for (int unsigned i = 1; i < COS_LATENCY; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign bus.x       = x_r;
  assign bus.x_valid = xv_r;
  assign bus.x_last  = xl_r;
  assign bus.y_valid = dl_q[COS_LATENCY-1].valid;
  assign bus.y_last  = dl_q[COS_LATENCY-1].last;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_qft_phase_sequencer.sv
// Self-checking bench for qft_phase_sequencer: table of bursts with hand-derived
// angles, a scoreboard for the x stream, per-cycle flag timing checks, and
// hand-written busy/done-cycle/reset sequences. QFT_PHASE_QUAD_EN adds x_q checks.
module tb_qft_phase_sequencer;
  import qft_phase_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  qft_phase_sequencer_if bus();

  qft_phase_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int xq;
    bit chk_q;
    bit last;
  } sb_t;

  typedef struct {
    int p0;
    int st;
    int n;
    int ex[8];
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;
  int   none8[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid x must match the next queued expectation.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && bus.x_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: unexpected x=%0d, expected no sample", int'(bus.x));
      end else begin
        e = sb_q.pop_front();
        chk("sb_x", int'(bus.x), e.x);
        chk("sb_last", int'(bus.x_last), int'(e.last));
`ifdef QFT_PHASE_QUAD_EN
        if (e.chk_q) chk("sb_xq", int'(bus.x_q), e.xq);
`endif
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, int'(bus.x), 0);
    chk({tag, "_x_valid"}, int'(bus.x_valid), 0);
    chk({tag, "_x_last"}, int'(bus.x_last), 0);
    chk({tag, "_y_valid"}, int'(bus.y_valid), 0);
    chk({tag, "_y_last"}, int'(bus.y_last), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
`ifdef QFT_PHASE_QUAD_EN
    chk({tag, "_x_q"}, int'(bus.x_q), 0);
`endif
  endtask

  // Runs one burst; inj_k >= 2 re-pulses start mid-burst, inj_done pulses it in the done cycle.
  task automatic run_burst(input int p0, input int st, input int n, input int ex[8],
                           input int exq[8], input bit cq, input int inj_k, input bit inj_done);
    int lat;
    int done_k;
    sb_t e;
    lat = int'(COS_LATENCY);
    for (int i = 0; i < n; i++) begin
      e.x = ex[i];
      e.xq = exq[i];
      e.chk_q = cq;
      e.last = (i == n - 1);
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.phase0 = ANGLE_W'(p0);
    bus.step   = ANGLE_W'(st);
    bus.count  = CNT_W'(n);
    bus.start  = 1'b1;
    done_k = (n == 0) ? 1 : n + lat + 1;
    for (int k = 0; k <= done_k; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (k == inj_k) begin
        bus.start  = 1'b1;
        bus.phase0 = ANGLE_W'(37);
        bus.count  = CNT_W'(9);
      end else if (k == inj_k + 1) begin
        bus.start = 1'b0;
      end
      chk("x_valid", int'(bus.x_valid), int'(k >= 1 && k <= n));
      chk("x_last", int'(bus.x_last), int'(n > 0 && k == n));
      chk("y_valid", int'(bus.y_valid), int'(k >= 1 + lat && k <= n + lat));
      chk("y_last", int'(bus.y_last), int'(n > 0 && k == n + lat));
      chk("busy", int'(bus.busy), int'(k < done_k));
      chk("done", int'(bus.done), int'(k == done_k));
    end
    if (inj_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("post_busy", int'(bus.busy), 0);
    chk("post_x_valid", int'(bus.x_valid), 0);
    chk("post_done", int'(bus.done), 0);
    @(negedge clk);
    chk("post2_busy", int'(bus.busy), 0);
    chk("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) none8[i] = 0;
    vecs[0] = '{0, 13, 4, '{0, 13, 26, 39, 0, 0, 0, 0}};
    vecs[1] = '{90, 20, 3, '{90, -91, -71, 0, 0, 0, 0, 0}};
    vecs[2] = '{-95, -10, 3, '{-95, 96, 86, 0, 0, 0, 0, 0}};
    vecs[3] = '{5, 7, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{100, 1, 2, '{100, -100, 0, 0, 0, 0, 0, 0}};
    vecs[5] = '{-101, -1, 2, '{-101, 99, 0, 0, 0, 0, 0, 0}};
    vecs[6] = '{150, 101, 3, '{-51, 50, -50, 0, 0, 0, 0, 0}};
    vecs[7] = '{-201, 0, 1, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[8] = '{-100, 101, 5, '{-100, 1, -99, 2, -98, 0, 0, 0}};
    vecs[9] = '{7, -3, 8, '{7, 4, 1, -2, -5, -8, -11, -14}};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.phase0 = '0;
    bus.step   = '0;
    bus.count  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    for (int v = 0; v < 10; v++) begin
      run_burst(vecs[v].p0, vecs[v].st, vecs[v].n, vecs[v].ex, none8, 1'b0, -1, 1'b0);
    end

    // start mid-burst is ignored; start during the done cycle is ignored too
    run_burst(10, 7, 5, '{10, 17, 24, 31, 38, 0, 0, 0}, none8, 1'b0, 2, 1'b1);

    // reset mid-burst aborts everything without a done pulse
    sb_q.push_back('{0, 0, 1'b0, 1'b0});
    sb_q.push_back('{13, 0, 1'b0, 1'b0});
    @(negedge clk);
    bus.phase0 = ANGLE_W'(0);
    bus.step   = ANGLE_W'(13);
    bus.count  = CNT_W'(4);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", int'(bus.busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    sb_q.delete();
    @(negedge clk);
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("after_reset_done", int'(bus.done), 0);
      chk("after_reset_busy", int'(bus.busy), 0);
    end
    run_burst(-30, 20, 3, '{-30, -10, 10, 0, 0, 0, 0, 0}, none8, 1'b0, -1, 1'b0);

`ifdef QFT_PHASE_QUAD_EN
    run_burst(0, 0, 2, '{0, 0, 0, 0, 0, 0, 0, 0}, '{-50, -50, 0, 0, 0, 0, 0, 0}, 1'b1, -1, 1'b0);
    run_burst(-80, 0, 1, '{-80, 0, 0, 0, 0, 0, 0, 0}, '{71, 0, 0, 0, 0, 0, 0, 0}, 1'b1, -1, 1'b0);
    run_burst(90, 20, 3, '{90, -91, -71, 0, 0, 0, 0, 0}, '{40, 60, 80, 0, 0, 0, 0, 0}, 1'b1, -1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
